// File: rtl/mac_pkg.sv
// Shared definitions for the mac stage and its dot-product sequencer.
// Width default and sequencer state encoding.
package mac_pkg;

  localparam int MAC_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    DONE
  } mac_dot_seq_state_t;

endpackage

// File: rtl/mac_dot_seq_if.sv
// Command, operand, mac and result channels of mac_dot_seq; slave is the sequencer side.
// The bias channel exists only when MAC_DOT_SEQ_BIAS_EN is defined.
interface mac_dot_seq_if
  import mac_pkg::*;
#(
  parameter int W     = MAC_W,
  parameter int LEN_W = 8
);

  logic [LEN_W-1:0] cmd_len;
  logic             cmd_vld, cmd_rdy;
  logic [W-1:0]     a, b;
  logic             a_vld, a_rdy, b_vld, b_rdy;
  logic [W-1:0]     mac_in0, mac_in1, mac_in2;
  logic             mac_in0_vld, mac_in0_rdy;
  logic             mac_in1_vld, mac_in1_rdy;
  logic             mac_in2_vld, mac_in2_rdy;
  logic [W-1:0]     mac_out0;
  logic             mac_out0_vld, mac_out0_rdy;
  logic [W-1:0]     res;
  logic             res_vld, res_rdy;
  logic             busy;
`ifdef MAC_DOT_SEQ_BIAS_EN
  logic [W-1:0]     bias;
  logic             bias_vld, bias_rdy;
`endif

  modport slave (
`ifdef MAC_DOT_SEQ_BIAS_EN
    input  bias, bias_vld,
    output bias_rdy,
`endif
    input  cmd_len, cmd_vld,
    output cmd_rdy,
    input  a, a_vld, b, b_vld,
    output a_rdy, b_rdy,
    output mac_in0, mac_in0_vld, mac_in1, mac_in1_vld, mac_in2, mac_in2_vld,
    input  mac_in0_rdy, mac_in1_rdy, mac_in2_rdy,
    input  mac_out0, mac_out0_vld,
    output mac_out0_rdy,
    output res, res_vld,
    input  res_rdy,
    output busy
  );

  modport master (
`ifdef MAC_DOT_SEQ_BIAS_EN
    output bias, bias_vld,
    input  bias_rdy,
`endif
    output cmd_len, cmd_vld,
    input  cmd_rdy,
    output a, a_vld, b, b_vld,
    input  a_rdy, b_rdy,
    input  mac_in0, mac_in0_vld, mac_in1, mac_in1_vld, mac_in2, mac_in2_vld,
    output mac_in0_rdy, mac_in1_rdy, mac_in2_rdy,
    output mac_out0, mac_out0_vld,
    input  mac_out0_rdy,
    input  res, res_vld,
    output res_rdy,
    input  busy
  );

endinterface

// File: rtl/mac_dot_seq.sv
// Feeds one a*b+acc term at a time to an external mac: 4 cycles/element, result in cycle 4N+1.
// a/b, mac and res_rdy stalls simply hold the current state; MAC_DOT_SEQ_BIAS_EN adds a bias that seeds acc.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int W     = MAC_W,
  parameter int LEN_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  mac_dot_seq_if.slave io
);

  mac_dot_seq_state_t state, state_nxt;

  logic [W-1:0]     acc, a_reg, b_reg, acc_init;
  logic [LEN_W-1:0] n_reg, cnt, cnt_inc;
  logic             sent0, sent1, sent2;
  logic             cmd_go, ab_go, out_go, res_go;
  logic             go0, go1, go2, all_sent;

`ifdef MAC_DOT_SEQ_BIAS_EN
  assign cmd_go   = (state == IDLE) & io.cmd_vld & io.bias_vld;
  assign acc_init = io.bias;
`else
  assign cmd_go   = (state == IDLE) & io.cmd_vld;
  assign acc_init = '0;
`endif

  // A and B only move together, so a lone valid never consumes an operand.
  assign ab_go    = (state == FETCH) & io.a_vld & io.b_vld;
  assign go0      = (state == ISSUE) & ~sent0 & io.mac_in0_rdy;
  assign go1      = (state == ISSUE) & ~sent1 & io.mac_in1_rdy;
  assign go2      = (state == ISSUE) & ~sent2 & io.mac_in2_rdy;
  assign all_sent = (sent0 | go0) & (sent1 | go1) & (sent2 | go2);
  assign out_go   = (state == WAIT) & io.mac_out0_vld;
  assign res_go   = (state == DONE) & io.res_rdy;
  assign cnt_inc  = cnt + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    io.cmd_rdy      = 1'b0;
    io.a_rdy        = 1'b0;
    io.b_rdy        = 1'b0;
    io.mac_in0      = '0;
    io.mac_in1      = '0;
    io.mac_in2      = '0;
    io.mac_in0_vld  = 1'b0;
    io.mac_in1_vld  = 1'b0;
    io.mac_in2_vld  = 1'b0;
    io.mac_out0_rdy = 1'b0;
    io.res          = '0;
    io.res_vld      = 1'b0;
    io.busy         = (state != IDLE);
`ifdef MAC_DOT_SEQ_BIAS_EN
    io.bias_rdy     = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef MAC_DOT_SEQ_BIAS_EN
        io.cmd_rdy  = io.cmd_vld & io.bias_vld;
        io.bias_rdy = io.cmd_vld & io.bias_vld;
`else
        io.cmd_rdy  = 1'b1;
`endif
        if (cmd_go) state_nxt = (io.cmd_len != '0) ? FETCH : DONE;
      end
      FETCH: begin
        io.a_rdy = io.a_vld & io.b_vld;
        io.b_rdy = io.a_vld & io.b_vld;
        if (ab_go) state_nxt = ISSUE;
      end
      ISSUE: begin
        io.mac_in0     = a_reg;
        io.mac_in1     = b_reg;
        io.mac_in2     = acc;
        io.mac_in0_vld = ~sent0;
        io.mac_in1_vld = ~sent1;
        io.mac_in2_vld = ~sent2;
        if (all_sent) state_nxt = WAIT;
      end
      WAIT: begin
        io.mac_out0_rdy = 1'b1;
        if (out_go) state_nxt = (cnt_inc == n_reg) ? DONE : FETCH;
      end
      DONE: begin
        io.res     = acc;
        io.res_vld = 1'b1;
        if (res_go) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      n_reg <= '0;
      a_reg <= '0;
      b_reg <= '0;
      sent0 <= 1'b0;
      sent1 <= 1'b0;
      sent2 <= 1'b0;
    end else begin
      if (cmd_go) begin
        n_reg <= io.cmd_len;
        acc   <= acc_init;
        cnt   <= '0;
      end
      if (ab_go) begin
        a_reg <= io.a;
        b_reg <= io.b;
      end
      // Channels may accept in different cycles; flags remember which already went.
      if (all_sent) begin
        sent0 <= 1'b0;
        sent1 <= 1'b0;
        sent2 <= 1'b0;
      end else begin
        sent0 <= sent0 | go0;
        sent1 <= sent1 | go1;
        sent2 <= sent2 | go2;
      end
      if (out_go) begin
        acc <= io.mac_out0;
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a two-stage mac model; bias cases run when MAC_DOT_SEQ_BIAS_EN is defined.
module tb_mac_dot_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_dot_seq_if #(.W(32), .LEN_W(8)) io ();
  mac_dot_seq #(.W(32), .LEN_W(8)) dut (.clk(clk), .rst(rst), .io(io));

`ifdef MAC_DOT_SEQ_BIAS_EN
  localparam logic [31:0] IDLE_CTL = 32'h000;
`else
  localparam logic [31:0] IDLE_CTL = 32'h100;
`endif

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic [31:0] in2_log[$];
  logic        gap_en = 1'b0;
  logic        skew = 1'b0;

  // mac model: input register stage, then output register held until taken
  logic [31:0] m0, m1, m2, m_out;
  logic        h0, h1, h2, m_vld, vld2_d;
  int n0 = 0, n1 = 0, n2 = 0, no = 0, na = 0, nb = 0, vld_any = 0, lone = 0;

  assign io.mac_in0_rdy  = 1'b1;
  assign io.mac_in1_rdy  = 1'b1;
  assign io.mac_in2_rdy  = skew ? vld2_d : 1'b1;
  assign io.mac_out0     = m_out;
  assign io.mac_out0_vld = m_vld;

  always @(posedge clk) begin
    if (rst) begin
      h0 <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
      m_vld <= 1'b0; m_out <= '0; vld2_d <= 1'b0;
    end else begin
      vld2_d <= io.mac_in2_vld;
      if (io.mac_in0_vld && io.mac_in0_rdy) begin m0 <= io.mac_in0; h0 <= 1'b1; end
      if (io.mac_in1_vld && io.mac_in1_rdy) begin m1 <= io.mac_in1; h1 <= 1'b1; end
      if (io.mac_in2_vld && io.mac_in2_rdy) begin m2 <= io.mac_in2; h2 <= 1'b1; end
      if (h0 && h1 && h2) begin
        m_out <= m0 * m1 + m2;
        m_vld <= 1'b1;
        h0 <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
        in2_log.push_back(m2);
      end else if (io.mac_out0_vld && io.mac_out0_rdy) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (io.mac_in0_vld && io.mac_in0_rdy) n0 <= n0 + 1;
    if (io.mac_in1_vld && io.mac_in1_rdy) n1 <= n1 + 1;
    if (io.mac_in2_vld && io.mac_in2_rdy) n2 <= n2 + 1;
    if (io.mac_out0_vld && io.mac_out0_rdy) no <= no + 1;
    if (io.mac_in0_vld || io.mac_in1_vld || io.mac_in2_vld) vld_any <= vld_any + 1;
    if ((io.a_vld && io.a_rdy) != (io.b_vld && io.b_rdy)) lone <= lone + 1;
    if (rst) begin
      a_q.delete();
      b_q.delete();
    end else begin
      if (io.a_vld && io.a_rdy && a_q.size() > 0) begin void'(a_q.pop_front()); na <= na + 1; end
      if (io.b_vld && io.b_rdy && b_q.size() > 0) begin void'(b_q.pop_front()); nb <= nb + 1; end
    end
  end

  // operand feeders, with optional independent random gaps
  initial begin
    io.a_vld = 1'b0; io.b_vld = 1'b0; io.a = '0; io.b = '0;
    forever begin
      @(negedge clk);
      io.a_vld = (a_q.size() > 0) && (!gap_en || $urandom_range(0, 2) != 0);
      io.a     = (a_q.size() > 0) ? a_q[0] : '0;
      io.b_vld = (b_q.size() > 0) && (!gap_en || $urandom_range(0, 2) != 0);
      io.b     = (b_q.size() > 0) ? b_q[0] : '0;
    end
  end

  function automatic logic [31:0] ctl();
    return {23'd0, io.cmd_rdy, io.a_rdy, io.b_rdy, io.mac_in0_vld, io.mac_in1_vld,
            io.mac_in2_vld, io.mac_out0_rdy, io.res_vld, io.busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [7:0] n, input logic [31:0] exp_res, input int exp_lat,
                         input int stall, input string tag);
    int lat;
    int k;
    @(negedge clk);
    io.cmd_len = n;
    io.cmd_vld = 1'b1;
    k = 0;
    while (!io.cmd_rdy && k < 50) begin @(negedge clk); k++; end
    check({tag, "_cmd_rdy"}, 32'(io.cmd_rdy), 32'd1);
    @(negedge clk);
    io.cmd_vld = 1'b0;
    lat = 1;
    while (!io.res_vld && lat < 600) begin @(negedge clk); lat++; end
    check({tag, "_res_vld"}, 32'(io.res_vld), 32'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, io.res, exp_res);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_res"}, io.res, exp_res);
    end
    io.res_rdy = 1'b1;
    @(negedge clk);
    io.res_rdy = 1'b0;
    check({tag, "_idle_ctl"}, ctl(), IDLE_CTL);
  endtask

  initial begin
    int b0, b1, b2, bo, ba, bb, bv;
    io.cmd_len = '0;
    io.cmd_vld = 1'b0;
    io.res_rdy = 1'b0;
`ifdef MAC_DOT_SEQ_BIAS_EN
    io.bias     = '0;
    io.bias_vld = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("reset_ctl", ctl(), IDLE_CTL);
    check("reset_in0", io.mac_in0, 32'd0);
    check("reset_in2", io.mac_in2, 32'd0);
    check("reset_res", io.res, 32'd0);
    rst = 1'b0;

    // basic: 1*4 + 2*5 + 3*6
    a_q = '{32'd1, 32'd2, 32'd3};
    b_q = '{32'd4, 32'd5, 32'd6};
    in2_log.delete();
    b0 = n0; b2 = n2; bo = no;
    run_cmd(8'd3, 32'd32, 13, 0, "basic");
    check("basic_in2_cnt", 32'(in2_log.size()), 32'd3);
    if (in2_log.size() >= 3) begin
      check("basic_in2_0", in2_log[0], 32'd0);
      check("basic_in2_1", in2_log[1], 32'd4);
      check("basic_in2_2", in2_log[2], 32'd14);
    end
    check("basic_n0", 32'(n0 - b0), 32'd3);
    check("basic_n2", 32'(n2 - b2), 32'd3);
    check("basic_out", 32'(no - bo), 32'd3);

    bv = vld_any;
    run_cmd(8'd0, 32'd0, 1, 0, "zero");
    check("zero_no_mac_vld", 32'(vld_any - bv), 32'd0);

    a_q = '{32'hFFFF_FFFD};
    b_q = '{32'd5};
    run_cmd(8'd1, 32'hFFFF_FFF1, 5, 0, "signed");

    a_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    b_q = '{32'd2, 32'd2};
    run_cmd(8'd2, 32'hFFFF_FFFC, 9, 0, "wrap");

    // backpressure and in2 skew: same result as the basic run
    gap_en = 1'b1;
    skew   = 1'b1;
    a_q = '{32'd1, 32'd2, 32'd3};
    b_q = '{32'd4, 32'd5, 32'd6};
    b0 = n0; b1 = n1; b2 = n2; bo = no; ba = na; bb = nb;
    run_cmd(8'd3, 32'd32, -1, 5, "stall");
    check("stall_n0", 32'(n0 - b0), 32'd3);
    check("stall_n1", 32'(n1 - b1), 32'd3);
    check("stall_n2", 32'(n2 - b2), 32'd3);
    check("stall_out", 32'(no - bo), 32'd3);
    check("stall_a", 32'(na - ba), 32'd3);
    check("stall_b", 32'(nb - bb), 32'd3);
    check("lone_operand", 32'(lone), 32'd0);
    gap_en = 1'b0;
    skew   = 1'b0;

    // reset during first WAIT cycle of element 2 (cycle 7) of an N=4 command
    a_q = '{32'd1, 32'd1, 32'd1, 32'd1};
    b_q = '{32'd2, 32'd2, 32'd2, 32'd2};
    b0 = n0; bo = no;
    @(negedge clk);
    io.cmd_len = 8'd4;
    io.cmd_vld = 1'b1;
    @(negedge clk);
    io.cmd_vld = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_wait_ctl", ctl(), 32'h005);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_idle_ctl", ctl(), IDLE_CTL);
    check("midrst_in2", io.mac_in2, 32'd0);
    check("midrst_n0", 32'(n0 - b0), 32'd2);
    check("midrst_out", 32'(no - bo), 32'd1);
    @(negedge clk);
    a_q = '{32'd7};
    b_q = '{32'd6};
    run_cmd(8'd1, 32'd42, 5, 0, "after_rst");

`ifdef MAC_DOT_SEQ_BIAS_EN
    @(negedge clk);
    io.cmd_len  = 8'd1;
    io.cmd_vld  = 1'b1;
    io.bias_vld = 1'b0;
    #1;
    check("bias_hold_cmd_rdy", 32'(io.cmd_rdy), 32'd0);
    check("bias_hold_bias_rdy", 32'(io.bias_rdy), 32'd0);
    @(negedge clk);
    io.cmd_vld  = 1'b0;
    io.bias_vld = 1'b1;
    check("bias_hold_busy", 32'(io.busy), 32'd0);
    io.bias = 32'd100;
    a_q = '{32'd2};
    b_q = '{32'd3};
    run_cmd(8'd1, 32'd106, 5, 0, "bias_n1");
    io.bias = 32'hFFFF_FFFF;
    run_cmd(8'd0, 32'hFFFF_FFFF, 1, 0, "bias_n0");
    io.bias = '0;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
